// File: rtl/mc_scpu_pkg.sv
// Shared types and encodings for the multi-cycle SCPU control unit.
// Optional performance counters in the top are enabled by MC_SCPU_PERF_EN.
package mc_scpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_LUI
    } inst_class_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_IMM = 2'b01;
    localparam logic [1:0] PCSRC_ALU = 2'b10;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;
    localparam logic [1:0] MTR_IMM = 2'b11;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/mc_scpu_decode.sv
// Combinational instruction decode: opcode/funct fields to class, legality
// and the static datapath selects that follow the latched instruction.
module mc_scpu_decode
    import mc_scpu_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_b5,
    output inst_class_e inst_class,
    output logic        legal,
    output logic [2:0]  imm_sel,
    output logic        alu_src_b,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  mem_to_reg
);

    always_comb begin
        inst_class = CL_I;
        legal      = 1'b1;
        imm_sel    = IMM_I;
        alu_src_b  = 1'b1;
        alu_ctrl   = {1'b0, funct3};
        mem_to_reg = MTR_ALU;
        case (opcode)
            OP_R: begin
                inst_class = CL_R;
                alu_src_b  = 1'b0;
                alu_ctrl   = {funct7_b5, funct3};
            end
            OP_I: begin
                // Only the right shifts carry an op-select bit in funct7
                if (funct3 == 3'b101) alu_ctrl = {funct7_b5, 3'b101};
            end
            OP_LOAD: begin
                inst_class = CL_LOAD;
                alu_ctrl   = ALU_ADD;
                mem_to_reg = MTR_MEM;
            end
            OP_STORE: begin
                inst_class = CL_STORE;
                imm_sel    = IMM_S;
                alu_ctrl   = ALU_ADD;
            end
            OP_BRANCH: begin
                inst_class = CL_BRANCH;
                imm_sel    = IMM_B;
                alu_src_b  = 1'b0;
                alu_ctrl   = ALU_SUB;
                legal      = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            OP_JAL: begin
                inst_class = CL_JAL;
                imm_sel    = IMM_J;
                alu_ctrl   = ALU_ADD;
                mem_to_reg = MTR_PC4;
            end
            OP_JALR: begin
                inst_class = CL_JALR;
                alu_ctrl   = ALU_ADD;
                mem_to_reg = MTR_PC4;
            end
            OP_LUI: begin
                inst_class = CL_LUI;
                imm_sel    = IMM_U;
                alu_ctrl   = ALU_ADD;
                mem_to_reg = MTR_IMM;
            end
            default: begin
                legal    = 1'b0;
                alu_ctrl = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/mc_scpu_ctrl.sv
// Multi-cycle RV32I-subset control FSM with MIO_ready wait states, wait timeout
// and sticky fault. Define MC_SCPU_PERF_EN to add cycle/instret counters.
module mc_scpu_ctrl
    import mc_scpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MIO_ready,
    input  logic [31:0] inst_in,
    input  logic        ALU_zero,
    output logic [31:0] IR_out,
    output logic [31:0] pc_rst_val,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemRW,
    output logic        CPU_MIO,
    output logic        ALUSrc_B,
    output logic [1:0]  PCSrc,
    output logic [1:0]  MemtoReg,
    output logic [2:0]  ImmSel,
    output logic [3:0]  ALU_Control,
    output logic [2:0]  state_out,
    output logic        fault
`ifdef MC_SCPU_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_e      state, state_next;
    logic [31:0] ir_q;
    logic [7:0]  wait_cnt;
    logic        wait_expired;
    logic        wait_clr;
    logic        wait_inc;
    inst_class_e dec_class;
    logic        dec_legal;
    logic        br_taken;

    mc_scpu_decode u_decode (
        .opcode     (ir_q[6:0]),
        .funct3     (ir_q[14:12]),
        .funct7_b5  (ir_q[30]),
        .inst_class (dec_class),
        .legal      (dec_legal),
        .imm_sel    (ImmSel),
        .alu_src_b  (ALUSrc_B),
        .alu_ctrl   (ALU_Control),
        .mem_to_reg (MemtoReg)
    );

    assign wait_expired = (wait_cnt == TIMEOUT_C) && !MIO_ready;
    assign br_taken     = ir_q[12] ? !ALU_zero : ALU_zero;
    // The counter restarts whenever a wait state is freshly entered
    assign wait_clr     = (state_next != state) &&
                          ((state_next == S_FETCH) || (state_next == S_MEM));
    assign wait_inc     = ((state == S_FETCH) || (state == S_MEM)) && !MIO_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            ir_q     <= INST_NOP;
            wait_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if (IRWrite) ir_q <= inst_in;
            if (wait_clr)      wait_cnt <= 8'd0;
            else if (wait_inc) wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemRW      = 1'b0;
        CPU_MIO    = 1'b0;
        PCSrc      = PCSRC_PC4;
        case (state)
            S_FETCH: begin
                CPU_MIO = 1'b1;
                if (MIO_ready) begin
                    IRWrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_expired) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: state_next = dec_legal ? S_EXEC : S_FAULT;
            S_EXEC: begin
                case (dec_class)
                    CL_BRANCH: begin
                        PCWrite    = 1'b1;
                        PCSrc      = br_taken ? PCSRC_IMM : PCSRC_PC4;
                        state_next = S_FETCH;
                    end
                    CL_LOAD, CL_STORE: state_next = S_MEM;
                    default:           state_next = S_WB;
                endcase
            end
            S_MEM: begin
                CPU_MIO = 1'b1;
                MemRW   = (dec_class == CL_STORE);
                if (MIO_ready) begin
                    if (dec_class == CL_STORE) begin
                        PCWrite    = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (wait_expired) begin
                    state_next = S_FAULT;
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
                state_next = S_FETCH;
                if (dec_class == CL_JAL)       PCSrc = PCSRC_IMM;
                else if (dec_class == CL_JALR) PCSrc = PCSRC_ALU;
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_FAULT;
        endcase
        // Reset abandons any bus request immediately, not on the next edge
        if (rst) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemRW    = 1'b0;
            CPU_MIO  = 1'b0;
            PCSrc    = PCSRC_PC4;
        end
    end

    assign IR_out     = ir_q;
    assign pc_rst_val = RESET_PC;
    assign state_out  = state;
    assign fault      = (state == S_FAULT);

`ifdef MC_SCPU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else if (state != S_FAULT) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (PCWrite) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_scpu_ctrl.sv
// Directed bench for mc_scpu_ctrl: reset, R/LW/SW/branch sequencing, wait
// states, timeout fault, illegal opcode and reset during a memory wait.
module tb_mc_scpu_ctrl;

    localparam logic [31:0] INST_ADD  = 32'h002081B3;
    localparam logic [31:0] INST_LW   = 32'h00802283;
    localparam logic [31:0] INST_SW   = 32'h0020A223;
    localparam logic [31:0] INST_BEQ  = 32'h00108863;
    localparam logic [31:0] INST_BNE  = 32'h00109863;
    localparam logic [31:0] INST_FNC  = 32'h0000000F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MIO_ready = 1'b0;
    logic        ALU_zero = 1'b0;
    logic [31:0] inst_in = 32'h0000_0013;
    logic [31:0] IR_out, pc_rst_val;
    logic        IRWrite, PCWrite, RegWrite, MemRW, CPU_MIO, ALUSrc_B, fault;
    logic [1:0]  PCSrc, MemtoReg;
    logic [2:0]  ImmSel, state_out;
    logic [3:0]  ALU_Control;
    logic [4:0]  strobes;
`ifdef MC_SCPU_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign strobes = {IRWrite, PCWrite, RegWrite, MemRW, CPU_MIO};

    mc_scpu_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .MIO_ready   (MIO_ready),
        .inst_in     (inst_in),
        .ALU_zero    (ALU_zero),
        .IR_out      (IR_out),
        .pc_rst_val  (pc_rst_val),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .RegWrite    (RegWrite),
        .MemRW       (MemRW),
        .CPU_MIO     (CPU_MIO),
        .ALUSrc_B    (ALUSrc_B),
        .PCSrc       (PCSrc),
        .MemtoReg    (MemtoReg),
        .ImmSel      (ImmSel),
        .ALU_Control (ALU_Control),
        .state_out   (state_out),
        .fault       (fault)
`ifdef MC_SCPU_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        MIO_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        MIO_ready = 1'b1;
        inst_in = INST_ADD;
        tick();
        #1;
        checks++;
        if (strobes !== 5'b00000) begin
            errors++; $display("FAIL reset_strobes got=%b exp=00000", strobes);
        end
        tick();
        rst = 1'b0;
        MIO_ready = 1'b0;
        #1;
        checks++;
        if (state_out !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_out); end
        checks++;
        if (IR_out !== 32'h0000_0013) begin errors++; $display("FAIL reset_ir got=%h exp=00000013", IR_out); end
        checks++;
        if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
        checks++;
        if ({ImmSel, ALU_Control, PCSrc, MemtoReg} !== 11'd0) begin
            errors++; $display("FAIL reset_selects got=%b %b %b %b exp=0", ImmSel, ALU_Control, PCSrc, MemtoReg);
        end
        checks++;
        if (strobes !== 5'b00001) begin errors++; $display("FAIL reset_fetch_strobes got=%b exp=00001", strobes); end
        checks++;
        if (pc_rst_val !== 32'h0) begin errors++; $display("FAIL pc_rst_val got=%h exp=0", pc_rst_val); end
    endtask

    task automatic test_add();
        logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        logic [4:0] exp_sb [4] = '{5'b10001, 5'b00000, 5'b00000, 5'b01100};
        inst_in = INST_ADD;
        MIO_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (state_out !== exp_st[i]) begin errors++; $display("FAIL add_state c%0d got=%0d exp=%0d", i, state_out, exp_st[i]); end
            checks++;
            if (strobes !== exp_sb[i]) begin errors++; $display("FAIL add_strobes c%0d got=%b exp=%b", i, strobes, exp_sb[i]); end
            if (i == 3) begin
                checks++;
                if ({ALU_Control, MemtoReg, PCSrc} !== 8'd0) begin
                    errors++; $display("FAIL add_wb_sel got=%b %b %b exp=0000 00 00", ALU_Control, MemtoReg, PCSrc);
                end
            end
            tick();
        end
        #1;
        checks++;
        if (state_out !== 3'd0) begin errors++; $display("FAIL add_return got=%0d exp=0", state_out); end
    endtask

    task automatic test_lw_wait();
        logic       rdy    [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        logic [4:0] exp_sb [8] = '{5'b10001, 5'b00000, 5'b00000, 5'b00001,
                                   5'b00001, 5'b00001, 5'b00001, 5'b01100};
        inst_in = INST_LW;
        for (int i = 0; i < 8; i++) begin
            MIO_ready = rdy[i];
            #1;
            checks++;
            if (state_out !== exp_st[i]) begin errors++; $display("FAIL lw_state c%0d got=%0d exp=%0d", i, state_out, exp_st[i]); end
            checks++;
            if (strobes !== exp_sb[i]) begin errors++; $display("FAIL lw_strobes c%0d got=%b exp=%b", i, strobes, exp_sb[i]); end
            if (i == 2) begin
                checks++;
                if ({ImmSel, ALUSrc_B, ALU_Control} !== 8'b000_1_0000) begin
                    errors++; $display("FAIL lw_exec_sel got=%0d %b %b exp=0 1 0000", ImmSel, ALUSrc_B, ALU_Control);
                end
            end
            if (i == 7) begin
                checks++;
                if (MemtoReg !== 2'b01) begin errors++; $display("FAIL lw_memtoreg got=%b exp=01", MemtoReg); end
            end
            tick();
        end
        MIO_ready = 1'b0;
        #1;
        checks++;
        if (state_out !== 3'd0) begin errors++; $display("FAIL lw_retire got=%0d exp=0", state_out); end
    endtask

    task automatic test_branch(input logic [31:0] inst, input logic zero,
                               input logic [1:0] exp_pcsrc, input string name);
        logic [2:0] exp_st [3] = '{3'd0, 3'd1, 3'd2};
        logic [4:0] exp_sb [3] = '{5'b10001, 5'b00000, 5'b01000};
        inst_in = inst;
        ALU_zero = zero;
        MIO_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state_out !== exp_st[i]) begin errors++; $display("FAIL %s_state c%0d got=%0d exp=%0d", name, i, state_out, exp_st[i]); end
            checks++;
            if (strobes !== exp_sb[i]) begin errors++; $display("FAIL %s_strobes c%0d got=%b exp=%b", name, i, strobes, exp_sb[i]); end
            if (i == 2) begin
                checks++;
                if ({PCSrc, ALU_Control, ImmSel} !== {exp_pcsrc, 4'b1000, 3'd2}) begin
                    errors++; $display("FAIL %s_exec got=%b %b %0d exp=%b 1000 2", name, PCSrc, ALU_Control, ImmSel, exp_pcsrc);
                end
            end
            tick();
        end
        #1;
        checks++;
        if (state_out !== 3'd0) begin errors++; $display("FAIL %s_return got=%0d exp=0", name, state_out); end
        ALU_zero = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        MIO_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if ({state_out, fault} !== 4'b000_0) begin
                errors++; $display("FAIL tmo_wait c%0d got=%0d/%b exp=0/0", i, state_out, fault);
            end
            tick();
        end
        #1;
        checks++;
        if ({state_out, fault, strobes} !== {3'd7, 1'b1, 5'b00000}) begin
            errors++; $display("FAIL tmo_fault got=%0d/%b/%b exp=7/1/00000", state_out, fault, strobes);
        end
        MIO_ready = 1'b1;
        tick();
        #1;
        checks++;
        if ({state_out, fault, strobes} !== {3'd7, 1'b1, 5'b00000}) begin
            errors++; $display("FAIL tmo_sticky got=%0d/%b/%b exp=7/1/00000", state_out, fault, strobes);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        MIO_ready = 1'b0;
        #1;
        checks++;
        if ({state_out, fault} !== 4'b000_0) begin
            errors++; $display("FAIL tmo_clear got=%0d/%b exp=0/0", state_out, fault);
        end
    endtask

    task automatic test_ready_wins();
        do_reset();
        MIO_ready = 1'b0;
        inst_in = INST_ADD;
        for (int i = 0; i < 15; i++) tick();
        MIO_ready = 1'b1;
        #1;
        checks++;
        if ({state_out, strobes} !== {3'd0, 5'b10001}) begin
            errors++; $display("FAIL rdywin_fetch got=%0d/%b exp=0/10001", state_out, strobes);
        end
        tick();
        #1;
        checks++;
        if ({state_out, fault} !== {3'd1, 1'b0}) begin
            errors++; $display("FAIL rdywin_decode got=%0d/%b exp=1/0", state_out, fault);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        inst_in = INST_FNC;
        MIO_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (state_out !== 3'd1) begin errors++; $display("FAIL fence_decode got=%0d exp=1", state_out); end
        tick();
        #1;
        checks++;
        if ({state_out, fault, strobes} !== {3'd7, 1'b1, 5'b00000}) begin
            errors++; $display("FAIL fence_fault got=%0d/%b/%b exp=7/1/00000", state_out, fault, strobes);
        end
    endtask

    task automatic test_back_to_back_sw_rst();
        logic       rdy    [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [4:0] exp_sb [4] = '{5'b10001, 5'b00000, 5'b00000, 5'b01011};
        do_reset();
        inst_in = INST_SW;
        for (int i = 0; i < 4; i++) begin
            MIO_ready = rdy[i];
            #1;
            checks++;
            if (state_out !== exp_st[i]) begin errors++; $display("FAIL sw_state c%0d got=%0d exp=%0d", i, state_out, exp_st[i]); end
            checks++;
            if (strobes !== exp_sb[i]) begin errors++; $display("FAIL sw_strobes c%0d got=%b exp=%b", i, strobes, exp_sb[i]); end
            tick();
        end
        // Second store: hang in MEM, then reset mid-wait
        MIO_ready = 1'b1;
        #1;
        checks++;
        if (state_out !== 3'd0) begin errors++; $display("FAIL sw_retire got=%0d exp=0", state_out); end
        tick();
        MIO_ready = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if ({state_out, strobes} !== {3'd3, 5'b00011}) begin
            errors++; $display("FAIL sw_memwait got=%0d/%b exp=3/00011", state_out, strobes);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({state_out, CPU_MIO, strobes} !== {3'd3, 1'b0, 5'b00000}) begin
            errors++; $display("FAIL rst_mem_drop got=%0d/%b/%b exp=3/0/00000", state_out, CPU_MIO, strobes);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({state_out, IR_out, strobes} !== {3'd0, 32'h0000_0013, 5'b00001}) begin
            errors++; $display("FAIL rst_mem_fetch got=%0d/%h/%b exp=0/00000013/00001", state_out, IR_out, strobes);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_add();
        test_lw_wait();
        test_branch(INST_BEQ, 1'b1, 2'b01, "beq_taken");
        test_branch(INST_BNE, 1'b1, 2'b00, "bne_nottaken");
        test_branch(INST_BEQ, 1'b0, 2'b00, "beq_nottaken");
        test_timeout();
        test_ready_wins();
        test_illegal();
        test_back_to_back_sw_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
